// File: rtl/fpmul_pkg.sv
// Shared definitions for the FP multiplier datapath, its result stage and benches.
package fpmul_pkg;
  localparam int FP_W      = 32;
  localparam int FPMUL_LAT = 4;

  typedef logic [FP_W-1:0] fp32_t;
endpackage

// File: rtl/fpmul_res_fifo.sv
// First-word fall-through result FIFO. Pop must only be asserted while non-empty.
module fpmul_res_fifo #(
  parameter int DEPTH  = 8,
  parameter int DATA_W = 32
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    push,
  input  logic                    pop,
  input  logic [DATA_W-1:0]       din,
  output logic [DATA_W-1:0]       rdata,
  output logic [$clog2(DEPTH):0]  count,
  output logic                    empty,
  output logic                    full
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [DATA_W-1:0] mem_d [DEPTH];
  logic [PW-1:0]     wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]     rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]     count_q, count_d;

  // Next-state for storage, pointers and occupancy.
  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (push) begin
      mem_d[wr_ptr_q] = din;
      wr_ptr_d        = wr_ptr_q + PW'(1);
    end else begin
      wr_ptr_d = wr_ptr_q;
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + PW'(1);
    end else begin
      rd_ptr_d = rd_ptr_q;
    end
    case ({push, pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  // State registers; storage is cleared so the head reads zero out of reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mem_q    <= '{default: '0};
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  assign rdata = mem_q[rd_ptr_q];
  assign count = count_q;
  assign empty = (count_q == CW'(0));
  assign full  = (count_q == CW'(DEPTH));
endmodule

// File: rtl/fpmul_result_buffer_chk.sv
// Protocol checks for the result buffer: FIFO over/underflow and output stability under stall.
module fpmul_result_buffer_chk #(
  parameter int DATA_W = 32
) (
  input logic              clk,
  input logic              rst,
  input logic              push,
  input logic              pop,
  input logic              full,
  input logic              empty,
  input logic              out_valid,
  input logic              out_ready,
  input logic [DATA_W-1:0] out_data
);
  a_no_overflow: assert property (@(posedge clk) disable iff (rst) !(push && full && !pop));

  a_no_underflow: assert property (@(posedge clk) disable iff (rst) !(pop && empty));

  a_stall_stable: assert property (@(posedge clk) disable iff (rst)
    (out_valid && !out_ready) |=> (out_valid && $stable(out_data)));
endmodule

// File: rtl/fpmul_result_buffer.sv
// Result stage of the FP multiplier: latency-matched token pipe, credit-based issue
// control and an FWFT FIFO holding products until the consumer takes them.
module fpmul_result_buffer
  import fpmul_pkg::*;
#(
  parameter int DATA_W = FP_W,
  parameter int LAT    = FPMUL_LAT,
  parameter int DEPTH  = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [DATA_W-1:0]      fp_z,
  output logic [DATA_W-1:0]      out_data,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [$clog2(DEPTH):0] count
);
  localparam int SW = $clog2(DEPTH + LAT + 1) + 1;

  logic [LAT-1:0] tok_q, tok_d;
  logic           fire_s, push_s, pop_s, empty_s, full_s, credit_s;
  logic [SW-1:0]  inflight_s, committed_s;

  // Every in-flight product already owns a FIFO slot, so capture can never overflow.
  always_comb begin
    inflight_s = '0;
    for (int k = 0; k < LAT; k++) begin
      inflight_s = inflight_s + SW'(tok_q[k]);
    end
    committed_s = SW'(count) + inflight_s;
    credit_s    = (committed_s < SW'(DEPTH));
  end

  assign in_ready = !rst && credit_s;
  assign fire_s   = in_valid && in_ready;
  assign push_s   = tok_q[LAT-1];
  assign pop_s    = out_valid && out_ready;

  // Token shift register tracking accepted operands through the multiplier.
  always_comb begin
    tok_d    = tok_q;
    tok_d[0] = fire_s;
    for (int k = 1; k < LAT; k++) begin
      tok_d[k] = tok_q[k-1];
    end
  end

  // Token pipe state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tok_q <= '0;
    end else begin
      tok_q <= tok_d;
    end
  end

  fpmul_res_fifo #(
    .DEPTH  (DEPTH),
    .DATA_W (DATA_W)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push_s),
    .pop   (pop_s),
    .din   (fp_z),
    .rdata (out_data),
    .count (count),
    .empty (empty_s),
    .full  (full_s)
  );

  assign out_valid = !empty_s;

  fpmul_result_buffer_chk #(
    .DATA_W (DATA_W)
  ) u_chk (
    .clk       (clk),
    .rst       (rst),
    .push      (push_s),
    .pop       (pop_s),
    .full      (full_s),
    .empty     (empty_s),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data)
  );
endmodule

// File: tb/tb_fpmul_result_buffer.sv
// Scoreboard bench for fpmul_result_buffer with a behavioural stand-in for the multiplier.
module tb_fpmul_result_buffer;
  import fpmul_pkg::*;

  localparam int LAT   = FPMUL_LAT;
  localparam int DEPTH = 8;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  fp32_t       fp_z;
  fp32_t       out_data;
  logic        out_valid;
  logic        out_ready;
  logic [3:0]  count;

  fpmul_result_buffer #(.DATA_W(FP_W), .LAT(LAT), .DEPTH(DEPTH)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .fp_z      (fp_z),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .count     (count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int    n_checks = 0;
  int    n_pass   = 0;
  int    n_fire   = 0;
  int    n_tick   = 0;
  fp32_t exp_q[$];
  int    pop_ticks[$];
  logic  pv [LAT];
  fp32_t pd [LAT];
  fp32_t next_val;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_checks++;
    if (got === want) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, want);
  endtask

  task automatic clear_model();
    for (int k = 0; k < LAT; k++) begin
      pv[k] = 1'b0;
      pd[k] = 32'h0;
    end
    exp_q.delete();
  endtask

  // One clock: sample at posedge+1, settle scoreboard, advance the multiplier model.
  task automatic tick();
    logic fire;
    fire = in_valid && in_ready;
    if (out_valid && out_ready) begin
      if (exp_q.size() == 0) check("sb_underrun", 32'd1, 32'd0);
      else check("data", out_data, exp_q.pop_front());
      pop_ticks.push_back(n_tick);
    end
    if (fire) begin
      exp_q.push_back(next_val);
      n_fire++;
    end
    @(posedge clk);
    #1;
    n_tick++;
    for (int k = LAT - 1; k > 0; k--) begin
      pv[k] = pv[k-1];
      pd[k] = pd[k-1];
    end
    pv[0] = fire;
    pd[0] = next_val;
    if (fire) next_val = $urandom();
    fp_z = pv[LAT-1] ? pd[LAT-1] : $urandom();
  endtask

  initial begin
    int base;
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; fp_z = 32'h0;
    next_val = 32'h40400000;
    clear_model();
    repeat (2) @(posedge clk);
    #1;
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_in_ready",  32'(in_ready),  32'd0);
    check("rst_count",     32'(count),     32'd0);
    check("rst_out_data",  out_data,       32'd0);
    rst = 1'b0;
    #1;
    check("rel_in_ready", 32'(in_ready), 32'd1);

    // Single op: 1.5 * 2.0 = 3.0
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    repeat (LAT - 1) tick();
    check("single_early", 32'(out_valid), 32'd0);
    tick();
    check("single_valid", 32'(out_valid), 32'd1);
    check("single_data",  out_data, 32'h40400000);
    check("single_cnt1",  32'(count), 32'd1);
    out_ready = 1'b1;
    tick();
    check("single_cnt0", 32'(count), 32'd0);

    // Streaming with the consumer always ready
    pop_ticks.delete();
    base = n_fire;
    for (int i = 0; i < 40 && (n_fire - base) < 20; i++) begin
      in_valid = 1'b1;
      check("stream_rdy", 32'(in_ready), 32'd1);
      tick();
    end
    in_valid = 1'b0;
    check("stream_fires", 32'(n_fire - base), 32'd20);
    for (int i = 0; i < 40 && exp_q.size() != 0; i++) tick();
    check("stream_pops", 32'(pop_ticks.size()), 32'd20);
    if (pop_ticks.size() == 20)
      check("stream_contig", 32'(pop_ticks[19] - pop_ticks[0]), 32'd19);

    // Backpressure
    out_ready = 1'b0;
    base = n_fire;
    for (int i = 0; i < 30; i++) begin
      in_valid = 1'b1;
      tick();
    end
    check("bp_accepts", 32'(n_fire - base), 32'(DEPTH));
    check("bp_count",   32'(count), 32'(DEPTH));
    check("bp_ready",   32'(in_ready), 32'd0);
    base = n_fire;
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check("bp_reready", 32'(in_ready), 32'd1);
    for (int i = 0; i < 10; i++) tick();
    in_valid = 1'b0;
    check("bp_one_more", 32'(n_fire - base), 32'd1);
    check("bp_refull",   32'(count), 32'(DEPTH));

    // Capture and pop on the same edge at occupancy 7
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check("cp_cnt7a", 32'(count), 32'd7);
    base = n_fire;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    check("cp_fire", 32'(n_fire - base), 32'd1);
    repeat (LAT - 1) tick();
    check("cp_cnt7b",  32'(count), 32'd7);
    check("cp_noready", 32'(in_ready), 32'd0);
    out_ready = 1'b1;
    tick();
    check("cp_cnt7c", 32'(count), 32'd7);
    for (int i = 0; i < 40 && exp_q.size() != 0; i++) tick();
    check("cp_drained", 32'(exp_q.size()), 32'd0);
    check("cp_cnt0",    32'(count), 32'd0);

    // Reset with 2 buffered and 3 in flight
    out_ready = 1'b0;
    in_valid = 1'b1;
    repeat (2) tick();
    in_valid = 1'b0;
    repeat (LAT) tick();
    in_valid = 1'b1;
    repeat (3) tick();
    in_valid = 1'b0;
    check("mid_cnt2", 32'(count), 32'd2);
    #2;
    rst = 1'b1;
    #1;
    check("mid_out_valid", 32'(out_valid), 32'd0);
    check("mid_in_ready",  32'(in_ready),  32'd0);
    check("mid_count",     32'(count),     32'd0);
    clear_model();
    fp_z = $urandom();
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    for (int i = 0; i < LAT + 2; i++) begin
      check("post_rst_valid", 32'(out_valid), 32'd0);
      check("post_rst_count", 32'(count), 32'd0);
      tick();
    end
    check("post_rst_ready", 32'(in_ready), 32'd1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
